// File: rtl/dram_sdp_2kx16_pkg.sv
// Shared widths and word/address types
// for the 2k x 16 simple dual-port RAM.
package dram_pkg;

  localparam int DRAM_ADDR_W = 11;
  localparam int DRAM_DATA_W = 16;

  typedef logic [DRAM_ADDR_W-1:0] dram_addr_t;
  typedef logic [DRAM_DATA_W-1:0] dram_data_t;

endpackage

// File: rtl/dram_sdp_2kx16_if.sv
// Write/read port bundle of the SDP RAM.
// wr_data/wr_addr/wr_en/wr_addr_strobe/rd_addr
// in, rd_data out; rd_oce with DRAM_RD_OCE_EN.
interface dram_sdp_2kx16_if
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH = DRAM_ADDR_W,
  parameter int DATA_WIDTH = DRAM_DATA_W
);

  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;
  logic                  wr_addr_strobe;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
`ifdef DRAM_RD_OCE_EN
  logic                  rd_oce;
`endif

  modport master (
    output wr_data,
    output wr_addr,
    output wr_en,
    output wr_addr_strobe,
    output rd_addr,
`ifdef DRAM_RD_OCE_EN
    output rd_oce,
`endif
    input  rd_data
  );

  modport slave (
    input  wr_data,
    input  wr_addr,
    input  wr_en,
    input  wr_addr_strobe,
    input  rd_addr,
`ifdef DRAM_RD_OCE_EN
    input  rd_oce,
`endif
    output rd_data
  );

endinterface

// File: rtl/dram_sdp_2kx16_out_reg.sv
// Optional rd_data pipeline stage with clock
// enable. Ports: clk, rst, oce, din, dout.
module dram_out_reg
  import dram_pkg::*;
#(
  parameter int          DATA_WIDTH = DRAM_DATA_W,
  parameter int          OUTPUT_REG = 0,
  parameter int unsigned RST_VAL    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  oce,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] do_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_q <= DATA_WIDTH'(RST_VAL);
    end else if (oce) begin
      do_q <= din;
    end
  end

  // Without the stage the register is
  // left dangling and trimmed away.
  assign dout = (OUTPUT_REG != 0) ? do_q : din;

endmodule

// File: rtl/dram_sdp_2kx16.sv
// 2k x 16 distributed SDP RAM, registered read
// address, optional output reg (DRAM_RD_OCE_EN).
// Ports: clk, rst, bus (write + read port).
module dram_sdp_2kx16
  import dram_pkg::*;
#(
  parameter int          ADDR_WIDTH = DRAM_ADDR_W,
  parameter int          DATA_WIDTH = DRAM_DATA_W,
  parameter int          OUTPUT_REG = 0,
  parameter int unsigned RST_VAL    = 0
) (
  input logic clk,
  input logic rst,
  dram_sdp_2kx16_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wa_q;
  logic [ADDR_WIDTH-1:0] wa_eff;
  logic [ADDR_WIDTH-1:0] ra_q;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  oce;

  assign wa_eff = bus.wr_addr_strobe
                ? wa_q : bus.wr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_q <= '0;
    end else if (!bus.wr_addr_strobe) begin
      wa_q <= bus.wr_addr;
    end
  end

  // Array has no reset; rst only gates
  // the write so contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en) begin
      mem[wa_eff] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q <= ADDR_WIDTH'(RST_VAL);
    end else begin
      ra_q <= bus.rd_addr;
    end
  end

  assign ram_q = mem[ra_q];

`ifdef DRAM_RD_OCE_EN
  assign oce = bus.rd_oce;
`else
  assign oce = 1'b1;
`endif

  dram_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUTPUT_REG (OUTPUT_REG),
    .RST_VAL    (RST_VAL)
  ) u_out_reg (
    .clk  (clk),
    .rst  (rst),
    .oce  (oce),
    .din  (ram_q),
    .dout (bus.rd_data)
  );

endmodule

// File: tb/tb_dram_sdp_2kx16.sv
// Directed bench: drives an OUTPUT_REG=0 and
// an OUTPUT_REG=1 instance in lockstep.
module tb_dram_sdp_2kx16;
  import dram_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  dram_data_t wr_data = '0;
  dram_addr_t wr_addr = '0;
  logic       wr_en = 1'b0;
  logic       wr_addr_strobe = 1'b0;
  dram_addr_t rd_addr = '0;
  logic       rd_oce = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  dram_sdp_2kx16_if b0 ();
  dram_sdp_2kx16_if b1 ();

  assign b0.wr_data = wr_data;
  assign b0.wr_addr = wr_addr;
  assign b0.wr_en = wr_en;
  assign b0.wr_addr_strobe = wr_addr_strobe;
  assign b0.rd_addr = rd_addr;
  assign b1.wr_data = wr_data;
  assign b1.wr_addr = wr_addr;
  assign b1.wr_en = wr_en;
  assign b1.wr_addr_strobe = wr_addr_strobe;
  assign b1.rd_addr = rd_addr;
`ifdef DRAM_RD_OCE_EN
  assign b0.rd_oce = rd_oce;
  assign b1.rd_oce = rd_oce;
`endif

  dram_sdp_2kx16 #(.OUTPUT_REG(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  dram_sdp_2kx16 #(.OUTPUT_REG(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200;
    chk("rst_rd1", 32'(b1.rd_data), 32'h0);
    chk("rst_ra", 32'(dut0.ra_q), 32'h0);
    chk("rst_wa", 32'(dut0.wa_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    wr_en = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      wr_addr = dram_addr_t'(i);
      wr_data = dram_data_t'(16'hFFFF - i);
      tick();
    end
    wr_en = 1'b0;

    for (int i = 0; i <= 2048; i++) begin
      rd_addr = dram_addr_t'(i % 2048);
      tick();
      if (i < 2048)
        chk($sformatf("fill0_%0d", i),
            32'(b0.rd_data), 32'hFFFF - i);
      if (i > 0)
        chk($sformatf("fill1_%0d", i - 1),
            32'(b1.rd_data), 32'hFFFF - (i - 1));
    end

    wr_en = 1'b1;
    wr_addr = 11'd5;
    wr_data = 16'h1234;
    tick();
    wr_addr_strobe = 1'b1;
    wr_addr = 11'd9;
    wr_data = 16'hABCD;
    tick();
    wr_en = 1'b0;
    wr_addr_strobe = 1'b0;
    chk("strb_wa", 32'(dut0.wa_q), 32'd5);
    rd_addr = 11'd5;
    tick();
    chk("strb_a5", 32'(b0.rd_data), 32'hABCD);
    rd_addr = 11'd9;
    tick();
    chk("strb_a9", 32'(b0.rd_data), 32'hFFF6);
    chk("strb_a5r", 32'(b1.rd_data), 32'hABCD);
    tick();
    chk("strb_a9r", 32'(b1.rd_data), 32'hFFF6);

    rd_addr = 11'd100;
    wr_addr = 11'd100;
    wr_data = 16'h5A5A;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("rdw0", 32'(b0.rd_data), 32'h5A5A);
    tick();
    chk("rdw1", 32'(b1.rd_data), 32'h5A5A);

`ifdef DRAM_RD_OCE_EN
    rd_addr = 11'd10;
    tick();
    tick();
    chk("oce_pre", 32'(b1.rd_data), 32'hFFF5);
    rd_oce = 1'b0;
    rd_addr = 11'd20;
    tick();
    tick();
    chk("oce_hold", 32'(b1.rd_data), 32'hFFF5);
    chk("oce_ign0", 32'(b0.rd_data), 32'hFFEB);
    rd_oce = 1'b1;
    tick();
    chk("oce_run", 32'(b1.rd_data), 32'hFFEB);
`endif

    rd_addr = 11'd30;
    tick();
    tick();
    chk("pre_rst1", 32'(b1.rd_data), 32'hFFE1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_rd1", 32'(b1.rd_data), 32'h0);
    chk("mrst_ra", 32'(dut0.ra_q), 32'h0);
    chk("mrst_rd0", 32'(b0.rd_data), 32'hFFFF);
    wr_addr = 11'd7;
    wr_data = 16'h0000;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rst = 1'b0;
    rd_addr = 11'd7;
    tick();
    chk("blk_a7", 32'(b0.rd_data), 32'hFFF8);
    rd_addr = 11'd5;
    tick();
    chk("keep_a5", 32'(b0.rd_data), 32'hABCD);
    chk("blk_a7r", 32'(b1.rd_data), 32'hFFF8);
    rd_addr = 11'd100;
    tick();
    chk("keep_a100", 32'(b0.rd_data), 32'h5A5A);
    chk("keep_a5r", 32'(b1.rd_data), 32'hABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
